// File: rtl/reg_bank_pipelined.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bank_pipelined
//  Description : Parametrised register bank with per-register reset values,
//                bus read-only mask, bit-level bus write mask, 1/2-cycle read
//                pipeline, error pulses and a hardware status-update port.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_bank_pipelined #(
  parameter int                     WIDTH   = 8,
  parameter int                     DEPTH   = 16,
  parameter int                     ADDR    = 4,
  parameter int                     RD_LAT  = 1,
  parameter int                     NUM_OUT = 4,
  parameter logic [WIDTH*DEPTH-1:0] RST_VAL = (WIDTH*DEPTH)'(32'h2081_0000),
  parameter logic [DEPTH-1:0]       RO_MASK = '0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     WrEn,
  input  logic                     RdEn,
  input  logic [ADDR-1:0]          Address,
  input  logic [WIDTH-1:0]         WrData,
  input  logic [WIDTH-1:0]         WrMask,
  input  logic                     HwWrEn,
  input  logic [ADDR-1:0]          HwAddr,
  input  logic [WIDTH-1:0]         HwData,
  output logic [WIDTH-1:0]         RdData,
  output logic                     RdData_VLD,
  output logic                     Wr_Ack,
  output logic                     Err,
  output logic [NUM_OUT*WIDTH-1:0] REG_OUT
);

  logic [WIDTH-1:0] r_regs [DEPTH];

  logic             w_addr_ok;
  logic             w_ro_hit;
  logic [WIDTH-1:0] w_rd_data;
  logic             w_both;
  logic             w_rd_req;
  logic             w_wr_req;
  logic             w_wr_ok;
  logic             w_req_err;

  logic             r_wr_ack;
  logic             r_req_err;
  logic             r_s1_vld;
  logic             r_s1_err;
  logic [WIDTH-1:0] r_s1_data;

  logic             w_pipe_vld;
  logic             w_pipe_err;
  logic [WIDTH-1:0] w_pipe_data;

  // Decode the bus address: range check, read-only lookup and read mux.
  // Out-of-range addresses match no register, so the read mux yields zero.
  always_comb begin
    w_addr_ok = 1'b0;
    w_ro_hit  = 1'b0;
    w_rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (Address == ADDR'(i)) begin
        w_addr_ok = 1'b1;
        w_ro_hit  = RO_MASK[i];
        w_rd_data = r_regs[i];
      end
    end
  end

  // Simultaneous read and write is a protocol error and does nothing.
  assign w_both    = WrEn & RdEn;
  assign w_rd_req  = RdEn & ~WrEn;
  assign w_wr_req  = WrEn & ~RdEn;
  assign w_wr_ok   = w_wr_req & w_addr_ok & ~w_ro_hit;
  assign w_req_err = w_both | (w_wr_req & ~(w_addr_ok & ~w_ro_hit));

  // Register array: hardware update overrides a bus write to the same register.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= RST_VAL[i*WIDTH +: WIDTH];
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (HwWrEn && (HwAddr == ADDR'(i))) begin
          r_regs[i] <= HwData;
        end else if (w_wr_ok && (Address == ADDR'(i))) begin
          r_regs[i] <= (r_regs[i] & ~WrMask) | (WrData & WrMask);
        end
      end
    end
  end

  // Write acknowledge and immediate (write / collision) error pulses.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_wr_ack  <= 1'b0;
      r_req_err <= 1'b0;
    end else begin
      r_wr_ack  <= w_wr_ok;
      r_req_err <= w_req_err;
    end
  end

  // First read stage: samples the pre-update array value; data holds between reads.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_s1_vld  <= 1'b0;
      r_s1_err  <= 1'b0;
      r_s1_data <= '0;
    end else begin
      r_s1_vld <= w_rd_req;
      r_s1_err <= w_rd_req & ~w_addr_ok;
      if (w_rd_req) begin
        r_s1_data <= w_rd_data;
      end
    end
  end

  generate
    if (RD_LAT == 1) begin : g_lat1
      assign w_pipe_vld  = r_s1_vld;
      assign w_pipe_err  = r_s1_err;
      assign w_pipe_data = r_s1_data;
    end else if (RD_LAT == 2) begin : g_lat2
      logic             r_s2_vld;
      logic             r_s2_err;
      logic [WIDTH-1:0] r_s2_data;

      // Second read stage: forwards stage-one results, holding data when idle.
      always_ff @(posedge CLK) begin
        if (!RST) begin
          r_s2_vld  <= 1'b0;
          r_s2_err  <= 1'b0;
          r_s2_data <= '0;
        end else begin
          r_s2_vld <= r_s1_vld;
          r_s2_err <= r_s1_err;
          if (r_s1_vld) begin
            r_s2_data <= r_s1_data;
          end
        end
      end

      assign w_pipe_vld  = r_s2_vld;
      assign w_pipe_err  = r_s2_err;
      assign w_pipe_data = r_s2_data;
    end else begin : g_bad_lat
      $error("reg_bank_pipelined: RD_LAT must be 1 or 2");
      assign w_pipe_vld  = 1'b0;
      assign w_pipe_err  = 1'b0;
      assign w_pipe_data = '0;
    end
  endgenerate

  assign RdData     = w_pipe_data;
  assign RdData_VLD = w_pipe_vld;
  assign Wr_Ack     = r_wr_ack;
  // A read error lines up with its data; a write error from a later request may coincide.
  assign Err        = r_req_err | (w_pipe_vld & w_pipe_err);

  generate
    for (genvar g = 0; g < NUM_OUT; g++) begin : g_reg_out
      assign REG_OUT[g*WIDTH +: WIDTH] = r_regs[g];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_pipelined.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_bank_pipelined
//  Description : Self-checking bench. Instance A: 16 regs, 1-cycle read,
//                reg 1 read-only. Instance B: 12 regs, 2-cycle read.
//                Both share one stimulus stream and are tracked by an
//                event-scheduled model of the bank.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reg_bank_pipelined;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0, hw_en = 1'b0;
  logic [3:0]  addr = '0, hw_addr = '0;
  logic [7:0]  wr_data = '0, wr_mask = '0, hw_data = '0;

  logic [7:0]  rd_a, rd_b;
  logic        vld_a, vld_b, ack_a, ack_b, err_a, err_b;
  logic [31:0] out_a, out_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reg_bank_pipelined #(
    .WIDTH(8), .DEPTH(16), .ADDR(4), .RD_LAT(1), .NUM_OUT(4),
    .RST_VAL(128'h2081_0000), .RO_MASK(16'h0002)
  ) u_a (
    .CLK(clk), .RST(rst), .WrEn(wr_en), .RdEn(rd_en), .Address(addr),
    .WrData(wr_data), .WrMask(wr_mask), .HwWrEn(hw_en), .HwAddr(hw_addr),
    .HwData(hw_data), .RdData(rd_a), .RdData_VLD(vld_a), .Wr_Ack(ack_a),
    .Err(err_a), .REG_OUT(out_a)
  );

  reg_bank_pipelined #(
    .WIDTH(8), .DEPTH(12), .ADDR(4), .RD_LAT(2), .NUM_OUT(4),
    .RST_VAL(96'h2081_0000), .RO_MASK(12'h000)
  ) u_b (
    .CLK(clk), .RST(rst), .WrEn(wr_en), .RdEn(rd_en), .Address(addr),
    .WrData(wr_data), .WrMask(wr_mask), .HwWrEn(hw_en), .HwAddr(hw_addr),
    .HwData(hw_data), .RdData(rd_b), .RdData_VLD(vld_b), .Wr_Ack(ack_b),
    .Err(err_b), .REG_OUT(out_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Reads are scheduled as events due a fixed number of edges after the request.
  logic [7:0] mem [2][16];
  logic       pv  [2][4];
  logic [7:0] pd  [2][4];
  logic       pe  [2][4];
  logic [7:0] e_rd  [2];
  logic       e_vld [2];
  logic       e_ack [2];
  logic       e_err [2];
  int         cyc = 0;
  bit         chk_en = 1'b0;

  function automatic logic [7:0] rst_val(input int i);
    case (i)
      2:       return 8'h81;
      3:       return 8'h20;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_step(input int k);
    int lat, dep, a, slot;
    logic [15:0] ro;
    lat = (k == 0) ? 1 : 2;
    dep = (k == 0) ? 16 : 12;
    ro  = (k == 0) ? 16'h0002 : 16'h0000;
    a   = int'(addr);
    if (!rst) begin
      for (int i = 0; i < 16; i++) mem[k][i] = rst_val(i);
      for (int s = 0; s < 4; s++) pv[k][s] = 1'b0;
      e_rd[k] = 8'h00; e_vld[k] = 1'b0; e_ack[k] = 1'b0; e_err[k] = 1'b0;
      return;
    end
    e_vld[k] = 1'b0; e_ack[k] = 1'b0; e_err[k] = 1'b0;
    if (wr_en && rd_en) begin
      e_err[k] = 1'b1;
    end else if (rd_en) begin
      slot = (cyc + lat - 1) % 4;
      pv[k][slot] = 1'b1;
      pd[k][slot] = (a < dep) ? mem[k][a] : 8'h00;
      pe[k][slot] = (a >= dep);
    end else if (wr_en) begin
      if (a >= dep || ro[a]) e_err[k] = 1'b1;
      else begin
        e_ack[k]  = 1'b1;
        mem[k][a] = (mem[k][a] & ~wr_mask) | (wr_data & wr_mask);
      end
    end
    if (hw_en && int'(hw_addr) < dep) mem[k][hw_addr] = hw_data;
    slot = cyc % 4;
    if (pv[k][slot]) begin
      pv[k][slot] = 1'b0;
      e_rd[k]  = pd[k][slot];
      e_vld[k] = 1'b1;
      e_err[k] = e_err[k] | pe[k][slot];
    end
  endtask

  // Advance the model on each edge, then compare every output shortly after.
  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    cyc++;
    if (!rst) chk_en = 1'b1;
    #1;
    if (chk_en) begin
      chk("A_rd",  {24'h0, rd_a},  {24'h0, e_rd[0]});
      chk("A_vld", {31'h0, vld_a}, {31'h0, e_vld[0]});
      chk("A_ack", {31'h0, ack_a}, {31'h0, e_ack[0]});
      chk("A_err", {31'h0, err_a}, {31'h0, e_err[0]});
      chk("A_out", out_a, {mem[0][3], mem[0][2], mem[0][1], mem[0][0]});
      chk("B_rd",  {24'h0, rd_b},  {24'h0, e_rd[1]});
      chk("B_vld", {31'h0, vld_b}, {31'h0, e_vld[1]});
      chk("B_ack", {31'h0, ack_b}, {31'h0, e_ack[1]});
      chk("B_err", {31'h0, err_b}, {31'h0, e_err[1]});
      chk("B_out", out_b, {mem[1][3], mem[1][2], mem[1][1], mem[1][0]});
    end
  end

  // ---------------- stimulus ----------------
  task automatic op(input logic we, input logic re, input logic [3:0] a,
                    input logic [7:0] wd, input logic [7:0] wm,
                    input logic he, input logic [3:0] ha, input logic [7:0] hd);
    @(negedge clk);
    wr_en = we; rd_en = re; addr = a; wr_data = wd; wr_mask = wm;
    hw_en = he; hw_addr = ha; hw_data = hd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 4'd0, 8'h00);
  endtask

  task automatic rd(input logic [3:0] a);
    op(1'b0, 1'b1, a, 8'h00, 8'h00, 1'b0, 4'd0, 8'h00);
  endtask

  initial begin
    // Reset state
    idle(); idle();
    chk("rst_A_rd",  {24'h0, rd_a}, 32'h0);
    chk("rst_A_vld", {31'h0, vld_a}, 32'h0);
    chk("rst_A_out", out_a, 32'h2081_0000);
    chk("rst_B_out", out_b, 32'h2081_0000);
    rst = 1'b1;

    // Reads of reset values
    rd(4'd2);
    chk("t1_A_rd2", {23'h0, vld_a, rd_a}, 32'h181);
    rd(4'd3);
    chk("t1_A_rd3", {23'h0, vld_a, rd_a}, 32'h120);
    chk("t1_B_rd2", {23'h0, vld_b, rd_b}, 32'h181);
    idle();
    chk("t1_A_hold", {23'h0, vld_a, rd_a}, 32'h020);
    chk("t1_B_rd3",  {23'h0, vld_b, rd_b}, 32'h120);

    // Masked write
    op(1'b1, 1'b0, 4'd5, 8'hA0, 8'hFF, 1'b0, 4'd0, 8'h00);
    op(1'b1, 1'b0, 4'd5, 8'hFF, 8'h0F, 1'b0, 4'd0, 8'h00);
    chk("t2_A_ack", {31'h0, ack_a}, 32'h1);
    chk("t2_A_out", out_a, 32'h2081_0000);
    rd(4'd5);
    chk("t2_A_rd5", {24'h0, rd_a}, 32'hAF);

    // Read-only register on A; writable on B
    op(1'b1, 1'b0, 4'd1, 8'h55, 8'hFF, 1'b0, 4'd0, 8'h00);
    chk("t3_A_err_ack", {30'h0, err_a, ack_a}, 32'h2);
    chk("t3_A_out", out_a, 32'h2081_0000);
    chk("t3_B_ack", {31'h0, ack_b}, 32'h1);
    op(1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd1, 8'h55);
    chk("t3_A_hw", out_a, 32'h2081_5500);

    // Out-of-range read (B only) and read/write collision
    rd(4'd13);
    chk("t4_A_rd13", {22'h0, vld_a, err_a, rd_a}, 32'h200);
    op(1'b1, 1'b1, 4'd6, 8'h77, 8'hFF, 1'b0, 4'd0, 8'h00);
    chk("t4_A_both", {29'h0, vld_a, ack_a, err_a}, 32'h1);
    chk("t4_B_oor",  {22'h0, vld_b, err_b, rd_b}, 32'h300);
    rd(4'd6);
    chk("t4_A_rd6", {24'h0, rd_a}, 32'h00);

    // Bus/HW collision on reg 4, read during HW update
    op(1'b1, 1'b0, 4'd4, 8'h11, 8'hFF, 1'b1, 4'd4, 8'h22);
    chk("t6_A_ack", {31'h0, ack_a}, 32'h1);
    op(1'b0, 1'b1, 4'd4, 8'h00, 8'h00, 1'b1, 4'd4, 8'h33);
    chk("t6_A_old", {24'h0, rd_a}, 32'h22);
    rd(4'd4);
    chk("t6_A_new", {24'h0, rd_a}, 32'h33);
    chk("t6_B_old", {24'h0, rd_b}, 32'h22);
    op(1'b1, 1'b0, 4'd0, 8'h0F, 8'hFF, 1'b1, 4'd3, 8'h44);
    chk("t6_A_both", out_a, 32'h4481_550F);
    chk("t6_B_both", out_b, 32'h4481_550F);

    // Back-to-back reads with 2-cycle latency
    rd(4'd0); rd(4'd1); rd(4'd2);
    chk("t5_B_rd1", {23'h0, vld_b, rd_b}, 32'h155);
    idle();
    chk("t5_B_rd2", {23'h0, vld_b, rd_b}, 32'h181);
    idle();
    chk("t5_B_idle", {31'h0, vld_b}, 32'h0);

    // Reset flushes an in-flight read
    rd(4'd2);
    rst = 1'b0;
    rd(4'd3);
    chk("t5_B_flush", {23'h0, vld_b, rd_b}, 32'h000);
    chk("t5_A_flush", {23'h0, vld_a, rd_a}, 32'h000);
    rst = 1'b1;
    idle();
    chk("t5_B_novld", {31'h0, vld_b}, 32'h0);
    chk("t5_B_out", out_b, 32'h2081_0000);
    idle();

    // Out-of-range write on B, legal on A
    op(1'b1, 1'b0, 4'd14, 8'h99, 8'hFF, 1'b0, 4'd0, 8'h00);
    chk("t4_B_wr_oor", {30'h0, err_b, ack_b}, 32'h2);
    chk("t4_A_wr14",   {30'h0, err_a, ack_a}, 32'h1);
    idle(); idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, time %0t limit 100000", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
